// File: rtl/bcd_timer_display.sv
// N-digit BCD up/down timer (pause, auto-reload, turbo tick) plus the per-pixel
// digit selector that feeds the digit bitmap renderer one clock behind the pixel counters.
module bcd_timer_display #(
    parameter int unsigned DIGITS        = 3,
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned TURBO_DIV     = 16,
    parameter int unsigned POS_X         = 0,
    parameter int unsigned POS_Y         = 0,
    parameter int unsigned DIGIT_W_LOG2  = 4,
    parameter int unsigned DIGIT_H       = 32,
    parameter int unsigned BLANK_LZ      = 1
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [10:0]           pixelX,
    input  logic [10:0]           pixelY,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  up_mode,
    input  logic                  auto_reload,
    input  logic                  turbo,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  running,
    output logic                  finishCount,
    output logic [10:0]           offsetX,
    output logic [10:0]           offsetY,
    output logic                  InsideRectangle,
    output logic [3:0]            current_digit
);
    localparam int unsigned CW        = 4 * DIGITS;
    localparam int unsigned PS_W      = $clog2(TICKS_PER_SEC);
    localparam int unsigned CELL_W    = 2 ** DIGIT_W_LOG2;
    localparam logic [PS_W-1:0] LIM_NORM  = PS_W'(TICKS_PER_SEC - 1);
    localparam logic [PS_W-1:0] LIM_TURBO = PS_W'(TICKS_PER_SEC / TURBO_DIV - 1);
    localparam logic [11:0] X_LO     = 12'(POS_X);
    localparam logic [11:0] X_HI     = 12'(POS_X + DIGITS * CELL_W);
    localparam logic [11:0] Y_LO     = 12'(POS_Y);
    localparam logic [11:0] Y_HI     = 12'(POS_Y + DIGIT_H);
    localparam logic [10:0] OFS_MASK = 11'(CELL_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_count, w_count_nx, r_reload, w_reload_nx;
    logic            r_up, w_up_nx;
    logic [PS_W-1:0] r_ps, w_ps_nx, w_limit;
    logic            r_finish, w_finish_nx, r_running, w_tick;
    logic [CW-1:0]   w_clamped, w_inc, w_dec;
    logic            w_zero, w_all9, w_borrow, w_carry;
    logic [3:0]      w_lnib, w_cnib;

    // Clamp of the load value and ripple BCD increment/decrement of the count
    always_comb begin
        w_clamped = '0;
        w_inc     = '0;
        w_dec     = '0;
        w_zero    = 1'b1;
        w_all9    = 1'b1;
        w_borrow  = 1'b1;
        w_carry   = 1'b1;
        w_lnib    = '0;
        w_cnib    = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            w_lnib = load_value[4*i +: 4];
            w_clamped[4*i +: 4] = (w_lnib > 4'd9) ? 4'd9 : w_lnib;
            w_cnib = r_count[4*i +: 4];
            if (w_cnib != 4'd0) w_zero = 1'b0;
            if (w_cnib != 4'd9) w_all9 = 1'b0;
            if (w_borrow) begin
                w_dec[4*i +: 4] = (w_cnib == 4'd0) ? 4'd9 : w_cnib - 4'd1;
                w_borrow        = (w_cnib == 4'd0);
            end else begin
                w_dec[4*i +: 4] = w_cnib;
            end
            if (w_carry) begin
                w_inc[4*i +: 4] = (w_cnib == 4'd9) ? 4'd0 : w_cnib + 4'd1;
                w_carry         = (w_cnib == 4'd9);
            end else begin
                w_inc[4*i +: 4] = w_cnib;
            end
        end
    end

    // Next state: load beats pause beats start; a pause in RUN also holds the prescaler
    always_comb begin
        w_state_nx  = r_state;
        w_count_nx  = r_count;
        w_reload_nx = r_reload;
        w_up_nx     = r_up;
        w_ps_nx     = r_ps;
        w_finish_nx = 1'b0;
        w_tick      = 1'b0;
        w_limit     = turbo ? LIM_TURBO : LIM_NORM;
        if (load) begin
            w_count_nx  = w_clamped;
            w_reload_nx = w_clamped;
            w_up_nx     = up_mode;
            w_ps_nx     = '0;
            w_state_nx  = S_IDLE;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (pause) begin
                        w_state_nx = S_PAUSE;
                    end else if (r_ps >= w_limit) begin
                        w_ps_nx = '0;
                        w_tick  = 1'b1;
                    end else begin
                        w_ps_nx = r_ps + PS_W'(1);
                    end
                end
                S_IDLE, S_PAUSE: if (!pause && start) w_state_nx = S_RUN;
                default: ;
            endcase
            if (w_tick) begin
                if (r_up ? w_all9 : w_zero) begin
                    w_finish_nx = 1'b1;
                    if (auto_reload) w_count_nx = r_reload;
                    else             w_state_nx = S_DONE;
                end else begin
                    w_count_nx = r_up ? w_inc : w_dec;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_reload  <= '0;
            r_up      <= 1'b0;
            r_ps      <= '0;
            r_finish  <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_count   <= w_count_nx;
            r_reload  <= w_reload_nx;
            r_up      <= w_up_nx;
            r_ps      <= w_ps_nx;
            r_finish  <= w_finish_nx;
            r_running <= (w_state_nx == S_RUN);
        end
    end

    logic [11:0] w_px, w_py;
    logic [10:0] w_relx, w_rely;
    logic [2:0]  w_idx;
    logic [3:0]  w_digit;
    logic        w_inrect, w_lz, w_blank;
    logic [10:0] r_offx, r_offy;
    logic [3:0]  r_digit;
    logic        r_inside;

    // Digit cell under the pixel; w_lz stays high while every digit so far is zero
    always_comb begin
        w_px     = {1'b0, pixelX};
        w_py     = {1'b0, pixelY};
        w_inrect = (w_px >= X_LO) && (w_px < X_HI) && (w_py >= Y_LO) && (w_py < Y_HI);
        w_relx   = pixelX - 11'(POS_X);
        w_rely   = pixelY - 11'(POS_Y);
        w_idx    = 3'(w_relx >> DIGIT_W_LOG2);
        w_digit  = '0;
        w_blank  = 1'b0;
        w_lz     = (BLANK_LZ != 0);
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_count[4*(int'(DIGITS)-1-i) +: 4] != 4'd0) w_lz = 1'b0;
            if (w_idx == 3'(i)) begin
                w_digit = r_count[4*(int'(DIGITS)-1-i) +: 4];
                w_blank = w_lz && (i != int'(DIGITS) - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetN || !w_inrect) begin
            r_offx   <= '0;
            r_offy   <= '0;
            r_digit  <= '0;
            r_inside <= 1'b0;
        end else begin
            r_offx   <= w_relx & OFS_MASK;
            r_offy   <= w_rely;
            r_digit  <= w_digit;
            r_inside <= !w_blank;
        end
    end

    assign count_bcd       = r_count;
    assign running         = r_running;
    assign finishCount     = r_finish;
    assign offsetX         = r_offx;
    assign offsetY         = r_offy;
    assign InsideRectangle = r_inside;
    assign current_digit   = r_digit;
endmodule

// File: tb/tb_bcd_timer_display.sv
// Randomized scoreboard bench for bcd_timer_display using a decimal-integer reference model.
module tb_bcd_timer_display;
    localparam int DIGITS = 3;
    localparam int TPS    = 8;
    localparam int TDIV   = 4;
    localparam int PX0    = 100;
    localparam int PY0    = 50;
    localparam int WL2    = 4;
    localparam int DH     = 32;
    localparam int BLZ    = 1;
    localparam int CW     = 4 * DIGITS;
    localparam int CELLW  = 2 ** WL2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic          clk;
    logic          resetN, load, start, pause, up_mode, auto_reload, turbo;
    logic [10:0]   pixelX, pixelY;
    logic [CW-1:0] load_value;
    logic [CW-1:0] count_bcd;
    logic          running, finishCount, InsideRectangle;
    logic [10:0]   offsetX, offsetY;
    logic [3:0]    current_digit;

    bcd_timer_display #(
        .DIGITS(DIGITS), .TICKS_PER_SEC(TPS), .TURBO_DIV(TDIV), .POS_X(PX0), .POS_Y(PY0),
        .DIGIT_W_LOG2(WL2), .DIGIT_H(DH), .BLANK_LZ(BLZ)
    ) dut (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY), .load(load),
        .load_value(load_value), .start(start), .pause(pause), .up_mode(up_mode),
        .auto_reload(auto_reload), .turbo(turbo), .count_bcd(count_bcd), .running(running),
        .finishCount(finishCount), .offsetX(offsetX), .offsetY(offsetY),
        .InsideRectangle(InsideRectangle), .current_digit(current_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] cnt;
        logic          run;
        logic          fin;
        logic [10:0]   ox;
        logic [10:0]   oy;
        logic          ins;
        logic [3:0]    dig;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Shadow inputs, copied onto the DUT pins at each falling edge
    logic          s_rst = 1'b1, s_load = 1'b0, s_start = 1'b0, s_pause = 1'b0;
    logic          s_up = 1'b0, s_ar = 1'b0, s_turbo = 1'b0, s_randpix = 1'b1;
    logic [CW-1:0] s_ldv = '0;
    logic [10:0]   s_px = '0, s_py = '0;

    int m_state = M_IDLE, m_val = 0, m_reload = 0, m_ps = 0;
    bit m_up = 1'b0;

    function automatic int pow10(int e);
        int r = 1;
        for (int k = 0; k < e; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [CW-1:0] to_bcd(int v);
        logic [CW-1:0] r = '0;
        int t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: applies this cycle's inputs, pushes outputs expected after the edge
    task automatic model_step();
        exp_t e;
        int x, y, idx, lim, v, n;
        x = int'(s_px);
        y = int'(s_py);
        e.ox = '0; e.oy = '0; e.dig = '0; e.ins = 1'b0; e.fin = 1'b0;
        if (x >= PX0 && x < PX0 + DIGITS * CELLW && y >= PY0 && y < PY0 + DH) begin
            idx   = (x - PX0) / CELLW;
            e.ox  = 11'((x - PX0) % CELLW);
            e.oy  = 11'(y - PY0);
            e.dig = 4'((m_val / pow10(DIGITS - 1 - idx)) % 10);
            e.ins = !(BLZ != 0 && idx != DIGITS - 1 && m_val < pow10(DIGITS - 1 - idx));
        end
        if (s_rst) begin
            m_state = M_IDLE; m_val = 0; m_reload = 0; m_up = 1'b0; m_ps = 0;
            e.ox = '0; e.oy = '0; e.dig = '0; e.ins = 1'b0;
        end else if (s_load) begin
            v = 0;
            for (int k = 0; k < DIGITS; k++) begin
                n = int'(s_ldv[4*k +: 4]);
                if (n > 9) n = 9;
                v = v + n * pow10(k);
            end
            m_val = v; m_reload = v; m_up = s_up; m_ps = 0; m_state = M_IDLE;
        end else if (m_state == M_RUN) begin
            if (s_pause) begin
                m_state = M_PAUSE;
            end else begin
                lim = s_turbo ? TPS / TDIV - 1 : TPS - 1;
                if (m_ps >= lim) begin
                    m_ps = 0;
                    if ((m_up && m_val == pow10(DIGITS) - 1) || (!m_up && m_val == 0)) begin
                        e.fin = 1'b1;
                        if (s_ar) m_val = m_reload;
                        else      m_state = M_DONE;
                    end else begin
                        m_val = m_up ? m_val + 1 : m_val - 1;
                    end
                end else begin
                    m_ps = m_ps + 1;
                end
            end
        end else if ((m_state == M_IDLE || m_state == M_PAUSE) && !s_pause && s_start) begin
            m_state = M_RUN;
        end
        e.run = (m_state == M_RUN);
        e.cnt = to_bcd(m_val);
        q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        if (s_randpix) begin
            s_px = 11'($urandom_range(90, 160));
            s_py = 11'($urandom_range(40, 90));
        end
        resetN = s_rst; load = s_load; load_value = s_ldv; start = s_start; pause = s_pause;
        up_mode = s_up; auto_reload = s_ar; turbo = s_turbo; pixelX = s_px; pixelY = s_py;
        model_step();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(logic [CW-1:0] v, logic up, logic ar);
        s_ldv = v; s_up = up; s_ar = ar; s_load = 1'b1;
        step();
        s_load = 1'b0;
    endtask

    task automatic do_start();
        s_start = 1'b1;
        step();
        s_start = 1'b0;
    endtask

    task automatic pix(int x, int y);
        s_px = 11'(x); s_py = 11'(y);
        step();
    endtask

    // Monitor: every clock presents a full output set, compared against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("count_bcd", 32'(count_bcd), 32'(e.cnt));
                chk("running", 32'(running), 32'(e.run));
                chk("finishCount", 32'(finishCount), 32'(e.fin));
                chk("offsetX", 32'(offsetX), 32'(e.ox));
                chk("offsetY", 32'(offsetY), 32'(e.oy));
                chk("InsideRectangle", 32'(InsideRectangle), 32'(e.ins));
                chk("current_digit", 32'(current_digit), 32'(e.dig));
            end
        end
    end

    initial begin
        logic [CW-1:0] v;
        s_rst = 1'b1;
        run(2);
        s_rst = 1'b0;
        // Down count to zero, terminal tick, then DONE holds
        do_load(12'h012, 1'b0, 1'b0);
        do_start();
        run(125);
        // Up count with auto-reload across the all-9s terminal value
        do_load(12'h997, 1'b1, 1'b1);
        do_start();
        run(45);
        s_ar = 1'b0;
        // Pause with a mid-period prescaler, then resume in turbo
        do_load(12'h500, 1'b0, 1'b0);
        do_start();
        run(5);
        s_pause = 1'b1;
        step();
        s_pause = 1'b0;
        run(20);
        s_turbo = 1'b1;
        do_start();
        run(12);
        s_turbo = 1'b0;
        // Zero loaded in down mode terminates on the first tick
        do_load(12'h000, 1'b0, 1'b0);
        do_start();
        run(12);
        // Clamp with simultaneous start, then reset in the middle of RUN
        s_start = 1'b1;
        do_load(12'hA3F, 1'b0, 1'b0);
        s_start = 1'b0;
        run(2);
        do_start();
        run(10);
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        // Display corners and blanking
        do_load(12'h007, 1'b0, 1'b0);
        s_randpix = 1'b0;
        pix(132, 60); pix(110, 60); pix(148, 50); pix(147, 81);
        pix(147, 82); pix(100, 50); pix(99, 50); pix(116, 49);
        s_randpix = 1'b1;
        // Randomized traffic with boundary-biased load values
        for (int i = 0; i < 3000; i++) begin
            s_rst   = ($urandom_range(0, 299) == 0);
            s_load  = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 7))
                0: v = 12'h000;
                1: v = 12'h001;
                2: v = 12'h999;
                3: v = 12'h998;
                default: v = CW'($urandom);
            endcase
            s_ldv   = v;
            s_up    = 1'($urandom);
            s_ar    = 1'($urandom);
            s_start = ($urandom_range(0, 7) == 0);
            s_pause = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) s_turbo = ~s_turbo;
            step();
        end
        s_rst = 1'b0; s_load = 1'b0; s_start = 1'b0; s_pause = 1'b0;
        run(2);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/bcd_timer_display.md
Name: bcd_timer_display

Overview:
- Parametrised successor of the fixed 3-digit countdown display.
- Holds an N-digit BCD timer that can count down or up, pause and resume, auto-reload, and run at turbo speed.
- Also generates the per-pixel digit selection and offsets for the existing digit bitmap renderer.
- Sits between the frame pixel counters and the NumbersBitMap / RGB mux.

Parameters:
- DIGITS, 3: number of BCD digits, 1..6.
- TICKS_PER_SEC, 50_000_000: clk cycles per timer tick, >=2.
- TURBO_DIV, 16: tick-period divisor while turbo=1; TICKS_PER_SEC/TURBO_DIV must be >=1.
- POS_X, 0: left edge of the digit rectangle, in pixels.
- POS_Y, 0: top edge of the digit rectangle, in pixels.
- DIGIT_W_LOG2, 4: digit cell width is 2**DIGIT_W_LOG2 pixels.
- DIGIT_H, 32: digit cell height in pixels.
- BLANK_LZ, 1: 1 = suppress leading zeros (the least significant digit is never blanked).

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous, active-high reset. The name is kept for codebase consistency; polarity is high.
- pixelX  in  11  current pixel column.
- pixelY  in  11  current pixel row.
- load  in  1  load load_value; sets state to IDLE.
- load_value  in  4*DIGITS  BCD value to load.
- start  in  1  begin or resume counting.
- pause  in  1  suspend counting.
- up_mode  in  1  0 = count down, 1 = count up; sampled only on load.
- auto_reload  in  1  1 = reload and continue on terminal count.
- turbo  in  1  selects the short tick period.
- count_bcd  out  4*DIGITS  current BCD value.
- running  out  1  high while state is RUN.
- finishCount  out  1  one-cycle pulse on terminal count.
- offsetX  out  11  x offset inside the current digit cell.
- offsetY  out  11  y offset inside the current digit cell.
- InsideRectangle  out  1  pixel lies inside a non-blanked digit cell.
- current_digit  out  4  BCD value of the digit under the pixel.

Behaviour:
- Reset values:
  - state = IDLE; count_bcd = 0; direction register = down; prescaler = 0.
  - All outputs are 0.
- States:
  - IDLE: start -> RUN.
  - RUN: pause -> PAUSE. On terminal count -> DONE, or stay in RUN if auto_reload=1.
  - PAUSE: start -> RUN.
  - DONE: only load or reset leave this state.
- Priority within a cycle: resetN > load > pause > start.
- load:
  - count_bcd <= load_value; direction <= up_mode; prescaler <= 0; state <= IDLE.
  - Each nibble >9 is clamped to 9.
  - The last loaded value is kept in a reload register.
- Prescaler:
  - Counts only while state is RUN.
  - Limit is TICKS_PER_SEC-1, or TICKS_PER_SEC/TURBO_DIV-1 when turbo=1.
  - tick asserts in the cycle where prescaler==limit, then prescaler wraps to 0.
  - If turbo switches so that prescaler>limit, tick asserts next cycle and prescaler wraps.
  - PAUSE holds the prescaler value; resuming continues from the held value.
- Tick, down mode:
  - BCD decrement with ripple borrow.
  - If the value is 0 before the tick: do not decrement.
  - finishCount=1 for one cycle.
  - auto_reload=1: count_bcd <= reload register.
  - auto_reload=0: state <= DONE.
- Tick, up mode:
  - BCD increment with ripple carry.
  - Terminal count is the all-9s value: no increment; finishCount pulses; reload register (auto_reload=1) or DONE.
- Loading 0 in down mode, or all-9s in up mode, then start:
  - Terminal count occurs on the first tick.
- running = (state==RUN), registered.
- Display path, one registered stage (outputs lag pixelX/pixelY by exactly 1 clk):
  - Rectangle: POS_X <= pixelX < POS_X + DIGITS*2**DIGIT_W_LOG2 and POS_Y <= pixelY < POS_Y + DIGIT_H.
  - Digit index = (pixelX-POS_X) >> DIGIT_W_LOG2. Index 0 is the most significant digit.
  - offsetX = (pixelX-POS_X) & (2**DIGIT_W_LOG2-1); offsetY = pixelY-POS_Y.
  - current_digit = nibble of count_bcd at that index.
  - InsideRectangle = in rectangle AND NOT blanked.
  - Blanked means BLANK_LZ=1, the digit and all more-significant digits are 0, and it is not the last digit.
  - Outside the rectangle, offsets and current_digit are 0.
- count_bcd updates are visible on the display path in the next cycle; no tearing protection is required.

Test Plan:
- Down count (DIGITS=3, TICKS_PER_SEC=4, auto_reload=0): load 0x012, start -> count_bcd reads 011, 010, 009 at 4-clk intervals. Reaching 000 pulses finishCount for exactly 1 clk; state DONE; running=0; value stays 000.
- Up count with auto-reload (DIGITS=2, TICKS_PER_SEC=2): load 0x97, up_mode=1, start -> 98, 99, then a finishCount pulse and count_bcd=97, still RUN.
- Pause/turbo (TICKS_PER_SEC=8, TURBO_DIV=4): pause at prescaler=5, hold 20 clks -> count_bcd is unchanged. Start with turbo=1 -> tick on the next cycle (5>1), then every 2 clks.
- Clamp and priority: load_value=0xA3F with load=start=1 in the same cycle -> count_bcd=939, state IDLE. Reset asserted mid-RUN -> all outputs 0 in the next cycle.
- Display (POS_X=100, POS_Y=50, DIGIT_W_LOG2=4, count_bcd=007, BLANK_LZ=1):
  - pixel (132,60) -> 1 clk later InsideRectangle=1, current_digit=7, offsetX=0, offsetY=10.
  - pixel (110,60) -> InsideRectangle=0 (blanked).
  - pixel (148,50) -> InsideRectangle=0 (outside).
- Edge of rectangle: pixel (147,81) -> InsideRectangle=1, offsetX=15, offsetY=31. Pixel (147,82) -> InsideRectangle=0.
